dsp_pipe_reg: RTL



---
 rtl/dsp_pipe_pkg.sv | 23 ++
 rtl/dsp_pipe_stage.sv | 72 +++++++
 rtl/dsp_pipe_reg.sv | 114 +++++++++++
 3 files changed

// File: rtl/dsp_pipe_pkg.sv
// Shared types and helpers for the DSP48A1 operand pipeline register.
// Stage control bundle, depth limits and the valid-chain popcount.
package dsp_pipe_pkg;

    localparam int MAX_DEPTH = 4;
    localparam int OCC_W     = 3;

    typedef struct packed {
        logic rst;
        logic flush;
        logic ce;
    } stage_ctrl_t;

    function automatic logic [OCC_W-1:0] popcount(input logic [MAX_DEPTH-1:0] vld);
        logic [OCC_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < MAX_DEPTH; i++) begin
            cnt = cnt + OCC_W'(vld[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/dsp_pipe_stage.sv
// One data+valid register stage with rst > flush > ce > hold priority (parity bit under DSP_PIPE_PARITY_EN).
// Latency: 1 enabled edge.
// No backpressure: ce low holds the stage, flush drops only the valid bit.
module dsp_pipe_stage
    import dsp_pipe_pkg::*;
#(
    parameter int               WIDTH   = 18,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  stage_ctrl_t      ctrl,
    input  logic [WIDTH-1:0] d_dat,
    input  logic             d_vld,
    output logic [WIDTH-1:0] q_dat,
    output logic             q_vld
`ifdef DSP_PIPE_PARITY_EN
    ,
    input  logic             d_par,
    output logic             q_par
`endif
);

    logic [WIDTH-1:0] dat_d, dat_q;
    logic             vld_d, vld_q;

    always_comb begin
        dat_d = dat_q;
        vld_d = vld_q;
        if (ctrl.flush) begin
            vld_d = 1'b0;
        end else if (ctrl.ce) begin
            dat_d = d_dat;
            vld_d = d_vld;
        end
    end

    always_ff @(posedge clk) begin
        if (ctrl.rst) begin
            dat_q <= RST_VAL;
            vld_q <= 1'b0;
        end else begin
            dat_q <= dat_d;
            vld_q <= vld_d;
        end
    end

    assign q_dat = dat_q;
    assign q_vld = vld_q;

`ifdef DSP_PIPE_PARITY_EN
    logic par_d, par_q;

    // Reset parity matches RST_VAL so a reset stage never looks corrupted.
    always_comb begin
        par_d = par_q;
        if (!ctrl.flush && ctrl.ce) begin
            par_d = d_par;
        end
    end

    always_ff @(posedge clk) begin
        if (ctrl.rst) begin
            par_q <= ^RST_VAL;
        end else begin
            par_q <= par_d;
        end
    end

    assign q_par = par_q;
`endif

endmodule

// File: rtl/dsp_pipe_reg.sv
// DSP48A1 operand pipeline: DEPTH stages of WIDTH bits with valid chain, flush, occupancy (parity via DSP_PIPE_PARITY_EN).
// Latency: DEPTH enabled edges d->q; DEPTH=0 is a combinational bypass.
// No backpressure: clk_en stalls every stage together; flush clears valids only.
module dsp_pipe_reg
    import dsp_pipe_pkg::*;
#(
    parameter int          WIDTH   = 18,
    parameter int          DEPTH   = 1,
    parameter logic [47:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clk_en,
    input  logic             flush,
    input  logic [WIDTH-1:0] d,
    input  logic             d_valid,
    output logic [WIDTH-1:0] q,
    output logic             q_valid,
    output logic [OCC_W-1:0] occupancy
`ifdef DSP_PIPE_PARITY_EN
    ,
    output logic             parity_err
`endif
);

    generate
        if (DEPTH < 0 || DEPTH > MAX_DEPTH || WIDTH < 1 || WIDTH > 48) begin : g_bad_cfg
            $error("dsp_pipe_reg: DEPTH must be 0..4 and WIDTH 1..48");
        end
    endgenerate

    localparam logic [WIDTH-1:0] RST_V = RST_VAL[WIDTH-1:0];

    stage_ctrl_t ctrl;
    assign ctrl = '{rst: rst, flush: flush, ce: clk_en};

    // Element 0 is the input port; element k is the output of stage k-1.
    logic [WIDTH-1:0] chain_dat [DEPTH+1];
    logic [DEPTH:0]   chain_vld;

    assign chain_dat[0] = d;
    assign chain_vld[0] = d_valid;

`ifdef DSP_PIPE_PARITY_EN
    logic [DEPTH:0] chain_par;
    assign chain_par[0] = ^d;
`endif

    generate
        for (genvar k = 0; k < DEPTH; k++) begin : g_stage
            dsp_pipe_stage #(
                .WIDTH   (WIDTH),
                .RST_VAL (RST_V)
            ) u_stage (
                .clk   (clk),
                .ctrl  (ctrl),
                .d_dat (chain_dat[k]),
                .d_vld (chain_vld[k]),
                .q_dat (chain_dat[k+1]),
                .q_vld (chain_vld[k+1])
`ifdef DSP_PIPE_PARITY_EN
                ,
                .d_par (chain_par[k]),
                .q_par (chain_par[k+1])
`endif
            );
        end
    endgenerate

    assign q       = chain_dat[DEPTH];
    assign q_valid = chain_vld[DEPTH];

    generate
        if (DEPTH == 0) begin : g_occ_zero
            assign occupancy = '0;
        end else begin : g_occ
            logic [MAX_DEPTH-1:0] vld_vec;
            assign vld_vec   = MAX_DEPTH'(chain_vld[DEPTH:1]);
            assign occupancy = popcount(vld_vec);
        end
    endgenerate

`ifdef DSP_PIPE_PARITY_EN
    generate
        if (DEPTH == 0) begin : g_perr_off
            assign parity_err = 1'b0;
        end else begin : g_perr
            logic perr_d, perr_q;

            // Checked on the word about to enter the last stage so the flag lines up with it on q.
            always_comb begin
                perr_d = perr_q;
                if (flush) begin
                    perr_d = 1'b0;
                end else if (clk_en) begin
                    perr_d = chain_vld[DEPTH-1] &&
                             ((^chain_dat[DEPTH-1]) != chain_par[DEPTH-1]);
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    perr_q <= 1'b0;
                end else begin
                    perr_q <= perr_d;
                end
            end

            assign parity_err = perr_q;
        end
    endgenerate
`endif

endmodule
